// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
//   Shared definitions for the boxcar decimator slice.
//   - acc_width():        accumulator width that can hold 2^max_r full-scale
//                         samples of data_w bits without wrapping.
//   - clamp_log2_ratio(): limits a requested log2 decimation ratio to max_r.
//   - out_state_t:        occupancy of the one-deep output holding register.
// ---------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic int acc_width(input int data_w, input int max_r);
        return data_w + max_r;
    endfunction

    function automatic logic [3:0] clamp_log2_ratio(input logic [3:0] r, input int max_r);
        if (int'(r) > max_r) begin
            return 4'(max_r);
        end
        return r;
    endfunction

endpackage

// File: rtl/decim_out_reg.sv
// ---------------------------------------------------------------------------
// decim_out_reg
//   One-deep valid/ready holding register for decimated results, with a
//   sticky overrun flag for results lost to back-pressure.
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   res, res_vld   new result and its strobe (one cycle per result)
//   dout           held result, stable while dout_valid & !dout_ready
//   dout_valid     dout holds an unconsumed result
//   dout_ready     consumer accepts dout this cycle
//   overrun        sticky: a result arrived while full and not being drained
//   clear_overrun  clears overrun (a same-cycle new overrun wins)
// ---------------------------------------------------------------------------
module decim_out_reg
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] res,
    input  logic                         res_vld,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         overrun,
    input  logic                         clear_overrun
);

    out_state_t st_p1;
    logic       drop;
    logic       load;

    always_comb begin
        // A result is accepted when the slot is empty or is being drained
        // this same cycle; otherwise it is lost.
        load = res_vld && ((st_p1 == OUT_EMPTY) || dout_ready);
        drop = res_vld && (st_p1 == OUT_FULL) && !dout_ready;
    end

    // ---- output stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            st_p1   <= OUT_EMPTY;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                dout  <= res;
                st_p1 <= OUT_FULL;
            end else if ((st_p1 == OUT_FULL) && dout_ready) begin
                st_p1 <= OUT_EMPTY;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign dout_valid = (st_p1 == OUT_FULL);

endmodule

// File: rtl/boxcar_decimator.sv
// ---------------------------------------------------------------------------
// boxcar_decimator
//   Accumulate-and-dump decimator: sums 2^R consecutive valid signed samples
//   and emits sum >>> R (mean, rounded toward -inf) as one output sample.
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   din, din_valid signed input sample and its strobe (no back-pressure)
//   log2_ratio     R; sampled at each block start, clamped to MAX_LOG2_RATIO
//   dout           signed decimated sample
//   dout_valid     dout holds an unconsumed result
//   dout_ready     consumer handshake
//   overrun        sticky flag: a result was dropped under back-pressure
//   clear_overrun  synchronous clear of overrun
// ---------------------------------------------------------------------------
module boxcar_decimator
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_LOG2_RATIO = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    input  logic [3:0]                   log2_ratio,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         overrun,
    input  logic                         clear_overrun
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LOG2_RATIO);
    localparam int CNT_W = MAX_LOG2_RATIO + 1;

    function automatic logic signed [DATA_WIDTH-1:0] mean_shift(
        input logic signed [ACC_W-1:0] s,
        input logic [3:0]              r
    );
        logic signed [ACC_W-1:0] t;
        t = s >>> r;
        return t[DATA_WIDTH-1:0];
    endfunction

    logic signed [ACC_W-1:0]      acc_p0;
    logic        [CNT_W-1:0]      cnt_p0;
    logic        [3:0]            r_act_p0;

    logic        [3:0]            r_eff;
    logic        [CNT_W-1:0]      last_cnt;
    logic signed [ACC_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] res_p0;
    logic                         vld_p0;

    always_comb begin
        // On the first sample of a block the ratio comes straight from the
        // port, so R=0 can close its single-sample block in the same cycle.
        r_eff    = (cnt_p0 == '0) ? clamp_log2_ratio(log2_ratio, MAX_LOG2_RATIO) : r_act_p0;
        last_cnt = (CNT_W'(1) << r_eff) - CNT_W'(1);
        sum      = acc_p0 + {{(ACC_W-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
        vld_p0   = din_valid && (cnt_p0 == last_cnt);
        res_p0   = mean_shift(sum, r_eff);
    end

    // ---- accumulate stage (p0) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p0   <= '0;
            cnt_p0   <= '0;
            r_act_p0 <= '0;
        end else if (din_valid) begin
            if (cnt_p0 == '0) begin
                r_act_p0 <= r_eff;
            end
            if (vld_p0) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum;
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    decim_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk          (clk),
        .rst          (rst),
        .res          (res_p0),
        .res_vld      (vld_p0),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

endmodule

// File: tb/tb_boxcar_decimator.sv
module tb_boxcar_decimator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] din = '0;
    logic               din_valid = 1'b0;
    logic [3:0]         log2_ratio = '0;
    logic signed [31:0] dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic               overrun;
    logic               clear_overrun = 1'b0;

    always #5 clk = ~clk;

    boxcar_decimator #(
        .DATA_WIDTH(32),
        .MAX_LOG2_RATIO(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .log2_ratio   (log2_ratio),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the current block as a list of samples; a result is
    // the arithmetic mean-by-shift of the list once it reaches 2^R entries.
    longint      blk[$];
    int          blk_r    = 0;
    bit          m_full   = 1'b0;
    logic [31:0] m_dout   = '0;
    bit          m_ovr    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic signed [31:0] d, input bit v, input int r,
                                input bit rdy, input bit clr, input bit rs);
        bit     got;
        longint s;
        longint res;
        bit     was_full;
        got = 1'b0;
        res = 0;
        if (rs) begin
            blk.delete();
            blk_r  = 0;
            m_full = 1'b0;
            m_dout = '0;
            m_ovr  = 1'b0;
            return;
        end
        if (v) begin
            if (blk.size() == 0) blk_r = (r > 10) ? 10 : r;
            blk.push_back(longint'(d));
            if (blk.size() == (1 << blk_r)) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                res = s >>> blk_r;
                got = 1'b1;
                blk.delete();
            end
        end
        was_full = m_full;
        if (got && (!was_full || rdy)) begin
            m_dout = res[31:0];
            m_full = 1'b1;
        end else if (was_full && rdy) begin
            m_full = 1'b0;
        end
        if (got && was_full && !rdy) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    // One clock: drive on the falling edge, model the rising edge, then
    // compare all outputs against the model shortly after it.
    task automatic step(input logic signed [31:0] d, input bit v, input int r,
                        input bit rdy, input bit clr, input bit rs);
        @(negedge clk);
        din           = d;
        din_valid     = v;
        log2_ratio    = 4'(r);
        dout_ready    = rdy;
        clear_overrun = clr;
        rst           = rs;
        @(posedge clk);
        model_update(d, v, r, rdy, clr, rs);
        #1;
        check("dout_valid", 32'(dout_valid), 32'(m_full));
        check("dout", dout, m_dout);
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_dout", dout, 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        // R=2, 1..4 -> 2, valid for one cycle
        for (int i = 1; i <= 4; i++) step(i, 1, 2, 1, 0, 0);
        check("t1_dout", dout, 32'd2);
        check("t1_valid", 32'(dout_valid), 32'd1);
        step(0, 0, 2, 1, 0, 0);
        check("t1_valid_drop", 32'(dout_valid), 32'd0);

        // R=2 negative -> -3 ; R=0 pass-through
        for (int i = 1; i <= 4; i++) step(-i, 1, 2, 1, 0, 0);
        check("t2_neg", dout, -32'sd3);
        step(5, 1, 0, 1, 0, 0);
        check("t2_r0_a", dout, 32'd5);
        step(-7, 1, 0, 1, 0, 0);
        check("t2_r0_b", dout, -32'sd7);
        check("t2_r0_vld", 32'(dout_valid), 32'd1);
        step(0, 0, 0, 1, 0, 0);

        // R=10 full scale with gaps
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 0, 10, 1, 0, 0);
            step(32'sh7FFFFFFF, 1, 10, 1, 0, 0);
            if (i < 1023) check("t3_no_early", 32'(dout_valid), 32'd0);
        end
        check("t3_full", dout, 32'h7FFFFFFF);
        step(0, 0, 10, 1, 0, 0);

        // Back-pressure and overrun
        step(10, 1, 1, 0, 0, 0);
        step(20, 1, 1, 0, 0, 0);
        step(30, 1, 1, 0, 0, 0);
        step(40, 1, 1, 0, 0, 0);
        check("t4_hold", dout, 32'd15);
        check("t4_ovr", 32'(overrun), 32'd1);
        step(0, 0, 1, 0, 1, 0);
        check("t4_clr", 32'(overrun), 32'd0);
        check("t4_still_held", dout, 32'd15);
        step(50, 1, 1, 0, 0, 0);
        step(60, 1, 1, 1, 0, 0);
        check("t4_swap", dout, 32'd55);
        check("t4_swap_vld", 32'(dout_valid), 32'd1);
        check("t4_swap_noovr", 32'(overrun), 32'd0);
        step(0, 0, 1, 1, 0, 0);

        // Mid-block ratio change takes effect at next block
        step(4, 1, 2, 1, 0, 0);
        step(8, 1, 2, 1, 0, 0);
        step(12, 1, 1, 1, 0, 0);
        check("t5_no_early", 32'(dout_valid), 32'd0);
        step(16, 1, 1, 1, 0, 0);
        check("t5_blk4", dout, 32'd10);
        step(100, 1, 1, 1, 0, 0);
        step(200, 1, 1, 1, 0, 0);
        check("t5_blk2", dout, 32'd150);

        // Reset mid-block discards partial sum
        step(0, 0, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1000, 1, 2, 1, 0, 0);
        step(0, 0, 2, 1, 0, 1);
        check("t6_rst_dout", dout, 32'd0);
        check("t6_rst_vld", 32'(dout_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(8, 1, 2, 1, 0, 0);
        check("t6_fresh", dout, 32'd8);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic signed [31:0] d;
            int r;
            d = $urandom;
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            step(d, ($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
